// File: rtl/imem_arbiter.sv
// Shares one single-port instruction BRAM between CPU fetch and a loader; fetch wins unless the loader has starved.
// Grants are combinational in the request cycle, and the response pulses exactly one cycle after the grant.
// A request is accepted only in its grant cycle; a requester that is not granted holds its request.
//
// Ports:
//   clk, rst                          clock and async active-high reset
//   fetch_req/addr -> fetch_gnt       CPU fetch request, accepted in the grant cycle
//   fetch_rvalid/rdata/err            fetch response, one cycle after the grant
//   load_req/we/addr/wdata -> load_gnt  loader read/write request
//   load_rvalid/rdata/err             loader response or write acknowledge
//   mem_en/we/addr/wdata, mem_rdata   BRAM port; read data is valid one cycle after mem_en
module imem_arbiter #(
    parameter int AW       = 12,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req,
    input  logic [31:0]   fetch_addr,
    output logic          fetch_gnt,
    output logic          fetch_rvalid,
    output logic [31:0]   fetch_rdata,
    output logic          fetch_err,
    input  logic          load_req,
    input  logic          load_we,
    input  logic [31:0]   load_addr,
    input  logic [31:0]   load_wdata,
    output logic          load_gnt,
    output logic          load_rvalid,
    output logic [31:0]   load_rdata,
    output logic          load_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_e;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    owner_e     owner_q, owner_d;
    logic       legal_q, legal_d;
    logic       write_q, write_d;
    logic [3:0] wait_q, wait_d;

    logic       starve;
    logic       fetch_legal;
    logic       load_legal;
    logic [31:0] rsp_data;

    // Word aligned and inside the 4*2^AW byte window of the BRAM.
    function automatic logic addr_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:AW+2] == '0);
    endfunction

    assign fetch_legal = addr_legal(fetch_addr);
    assign load_legal  = addr_legal(load_addr);

    // The loader overtakes fetch once it has waited MAX_WAIT cycles; granting it
    // clears the counter, so the override lasts exactly one cycle.
    assign starve    = (wait_q >= MAX_WAIT_C);
    assign load_gnt  = !rst && load_req && (!fetch_req || starve);
    assign fetch_gnt = !rst && fetch_req && !load_gnt;

    // Illegal grants are still accepted and answered, but never touch the BRAM.
    assign mem_en    = (fetch_gnt && fetch_legal) || (load_gnt && load_legal);
    assign mem_we    = load_gnt && load_legal && load_we;
    assign mem_wdata = mem_we ? load_wdata : 32'h0;

    always_comb begin
        mem_addr = '0;
        if (load_gnt && load_legal) begin
            mem_addr = load_addr[AW+1:2];
        end else if (fetch_gnt && fetch_legal) begin
            mem_addr = fetch_addr[AW+1:2];
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        legal_d = 1'b0;
        write_d = 1'b0;
        if (fetch_gnt) begin
            owner_d = OWN_FETCH;
            legal_d = fetch_legal;
        end else if (load_gnt) begin
            owner_d = OWN_LOAD;
            legal_d = load_legal;
            write_d = load_we;
        end
        // Cannot overflow: at MAX_WAIT (<= 15) the loader is granted and the count clears.
        wait_d = (load_req && !load_gnt) ? wait_q + 4'd1 : 4'd0;
    end

    // Response owner/kind register; reset drops any in-flight response at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_NONE;
            legal_q <= 1'b0;
            write_q <= 1'b0;
            wait_q  <= 4'd0;
        end else begin
            owner_q <= owner_d;
            legal_q <= legal_d;
            write_q <= write_d;
            wait_q  <= wait_d;
        end
    end

    // Only a legal read returns BRAM data; write acks and errors return zero.
    assign rsp_data = (legal_q && !write_q) ? mem_rdata : 32'h0;

    assign fetch_rvalid = (owner_q == OWN_FETCH);
    assign fetch_rdata  = fetch_rvalid ? rsp_data : 32'h0;
    assign fetch_err    = fetch_rvalid && !legal_q;

    assign load_rvalid  = (owner_q == OWN_LOAD);
    assign load_rdata   = load_rvalid ? rsp_data : 32'h0;
    assign load_err     = load_rvalid && !legal_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: a BRAM model, a transaction-level reference model checked every cycle,
// and hand-computed literal expectations for each scenario.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_imem_arbiter;

    localparam int AW       = 12;
    localparam int MAX_WAIT = 4;

    logic          clk;
    logic          rst;
    logic          fetch_req;
    logic [31:0]   fetch_addr;
    logic          fetch_gnt;
    logic          fetch_rvalid;
    logic [31:0]   fetch_rdata;
    logic          fetch_err;
    logic          load_req;
    logic          load_we;
    logic [31:0]   load_addr;
    logic [31:0]   load_wdata;
    logic          load_gnt;
    logic          load_rvalid;
    logic [31:0]   load_rdata;
    logic          load_err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    imem_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
        .load_req(load_req), .load_we(load_we), .load_addr(load_addr), .load_wdata(load_wdata),
        .load_gnt(load_gnt), .load_rvalid(load_rvalid), .load_rdata(load_rdata), .load_err(load_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: synchronous write, registered read.
    logic [31:0] bram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) bram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= bram[mem_addr];
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [0:(1<<AW)-1];
    int          wait_m;
    int          pend_own;     // 0 none, 1 fetch, 2 load
    logic [31:0] pend_rd;
    logic        pend_err;

    int n_vec;
    int n_bad;

    // Samples taken at the falling edge of the most recent step.
    logic        s_fg, s_lg, s_en, s_frv, s_fer, s_lrv, s_ler;
    logic [31:0] s_addr, s_frd, s_lrd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        int          who;
        logic [31:0] a;
        logic [63:0] lim;
        logic        legal;
        logic        is_wr;
        int          widx;
        if (rst) begin
            chk("rst_fetch_gnt", fetch_gnt, 0);
            chk("rst_load_gnt", load_gnt, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", 32'(mem_addr), 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_fetch_rvalid", fetch_rvalid, 0);
            chk("rst_fetch_rdata", fetch_rdata, 0);
            chk("rst_fetch_err", fetch_err, 0);
            chk("rst_load_rvalid", load_rvalid, 0);
            chk("rst_load_rdata", load_rdata, 0);
            chk("rst_load_err", load_err, 0);
            wait_m   = 0;
            pend_own = 0;
            return;
        end
        // Response owed from the previous cycle's grant.
        chk("fetch_rvalid", fetch_rvalid, (pend_own == 1) ? 1 : 0);
        chk("load_rvalid", load_rvalid, (pend_own == 2) ? 1 : 0);
        chk("fetch_rdata", fetch_rdata, (pend_own == 1) ? pend_rd : 0);
        chk("load_rdata", load_rdata, (pend_own == 2) ? pend_rd : 0);
        if (pend_own == 1) chk("fetch_err", fetch_err, pend_err);
        if (pend_own == 2) chk("load_err", load_err, pend_err);
        // Arbitration for this cycle.
        if (load_req && (wait_m >= MAX_WAIT || !fetch_req)) who = 2;
        else if (fetch_req)                                  who = 1;
        else                                                 who = 0;
        a     = (who == 2) ? load_addr : fetch_addr;
        lim   = 64'd4 << AW;
        legal = (who != 0) && (a % 4 == 0) && ({32'h0, a} < lim);
        is_wr = (who == 2) && load_we;
        widx  = int'(a / 4);
        chk("fetch_gnt", fetch_gnt, (who == 1) ? 1 : 0);
        chk("load_gnt", load_gnt, (who == 2) ? 1 : 0);
        chk("mem_en", mem_en, legal ? 1 : 0);
        chk("mem_we", mem_we, (legal && is_wr) ? 1 : 0);
        if (legal)          chk("mem_addr", 32'(mem_addr), a / 4);
        if (legal && is_wr) chk("mem_wdata", mem_wdata, load_wdata);
        // Next-cycle response and memory effect.
        pend_own = who;
        pend_err = (who != 0) && !legal;
        pend_rd  = (legal && !is_wr) ? ref_mem[widx] : 32'h0;
        if (legal && is_wr) ref_mem[widx] = load_wdata;
        wait_m = (load_req && who != 2) ? wait_m + 1 : 0;
    endtask

    task automatic step(input logic r, input logic fr, input logic [31:0] fa,
                        input logic lr, input logic lw, input logic [31:0] la, input logic [31:0] ld);
        rst        = r;
        fetch_req  = fr;
        fetch_addr = fa;
        load_req   = lr;
        load_we    = lw;
        load_addr  = la;
        load_wdata = ld;
        @(negedge clk);
        s_fg   = fetch_gnt;
        s_lg   = load_gnt;
        s_en   = mem_en;
        s_addr = 32'(mem_addr);
        s_frv  = fetch_rvalid;
        s_frd  = fetch_rdata;
        s_fer  = fetch_err;
        s_lrv  = load_rvalid;
        s_lrd  = load_rdata;
        s_ler  = load_err;
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] fa);
        step(1'b0, 1'b1, fa, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic load(input logic lw, input logic [31:0] la, input logic [31:0] ld);
        step(1'b0, 1'b0, 32'h0, 1'b1, lw, la, ld);
    endtask

    logic [10:0] lg_hist;
    logic [10:0] fg_hist;

    initial begin
        n_vec = 0;
        n_bad = 0;
        wait_m = 0;
        pend_own = 0;
        pend_rd = 0;
        pend_err = 0;
        rst = 1'b1;
        fetch_req = 0; fetch_addr = 0;
        load_req = 0; load_we = 0; load_addr = 0; load_wdata = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            bram[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
        bram[0] = 32'h11111111; ref_mem[0] = 32'h11111111;
        bram[1] = 32'h22222222; ref_mem[1] = 32'h22222222;
        bram[2] = 32'h33333333; ref_mem[2] = 32'h33333333;
        bram[5] = 32'h00000013; ref_mem[5] = 32'h00000013;

        // Reset with a request pending: nothing may be granted.
        step(1'b1, 1'b1, 32'h14, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("lit_rst_gnt", {31'h0, s_fg | s_lg}, 0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();

        // Fetch read of word 5.
        fetch(32'h14);
        chk("lit_fetch_gnt", s_fg, 1);
        chk("lit_fetch_addr", s_addr, 5);
        idle();
        chk("lit_fetch_rvalid", s_frv, 1);
        chk("lit_fetch_rdata", s_frd, 32'h00000013);
        chk("lit_fetch_err", s_fer, 0);

        // Loader write, then fetch of the same word on the next cycle.
        load(1'b1, 32'h100, 32'hDEADBEEF);
        fetch(32'h100);
        chk("lit_wr_ack", s_lrv, 1);
        chk("lit_wr_rdata", s_lrd, 0);
        idle();
        chk("lit_wr_then_rd", s_frd, 32'hDEADBEEF);
        load(1'b0, 32'h100, 32'h0);
        idle();
        chk("lit_load_rd", s_lrd, 32'hDEADBEEF);

        // Starvation: both requests held; loader wins every fifth cycle.
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
            lg_hist[i] = s_lg;
            fg_hist[i] = s_fg;
        end
        chk("lit_starve_load", 32'(lg_hist), 32'h210);
        chk("lit_starve_fetch", 32'(fg_hist), 32'h5EF);
        idle();
        idle();

        // Address errors.
        fetch(32'h102);
        chk("lit_ferr_en", s_en, 0);
        load(1'b0, 32'h4000, 32'h0);
        chk("lit_lerr_en", s_en, 0);
        chk("lit_ferr", s_fer, 1);
        chk("lit_ferr_rdata", s_frd, 0);
        load(1'b1, 32'h4000, 32'hFFFFFFFF);
        chk("lit_lwerr_en", s_en, 0);
        chk("lit_lerr", s_ler, 1);
        chk("lit_lerr_rdata", s_lrd, 0);
        idle();
        chk("lit_lwerr", s_ler, 1);
        fetch(32'h0);
        idle();
        chk("lit_no_alias_wr", s_frd, 32'h11111111);

        // Back-to-back fetches.
        fetch(32'h0);
        fetch(32'h4);
        chk("lit_b2b_0", s_frd, 32'h11111111);
        fetch(32'h8);
        chk("lit_b2b_1", s_frd, 32'h22222222);
        idle();
        chk("lit_b2b_2", s_frd, 32'h33333333);
        idle();

        // Reset in the cycle after a grant drops the response.
        fetch(32'h14);
        step(1'b1, 1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("lit_rst_drop", s_frv, 0);
        fetch(32'h14);
        chk("lit_post_rst_gnt", s_fg, 1);
        idle();
        chk("lit_post_rst_rdata", s_frd, 32'h00000013);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, default 12, word-address width of the instruction BRAM; MAX_WAIT, default 4, loader starvation limit in cycles (1..15).
REQ-002 Ports SHALL be:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, reset, asynchronous, active-high.
- fetch_req, in, 1, CPU fetch request.
- fetch_addr, in, 32, CPU byte address.
- fetch_gnt, out, 1, fetch request accepted this cycle.
- fetch_rvalid, out, 1, fetch response valid.
- fetch_rdata, out, 32, fetch data.
- fetch_err, out, 1, fetch address error, qualified by fetch_rvalid.
- load_req, in, 1, loader request.
- load_we, in, 1, loader write (1) or read (0).
- load_addr, in, 32, loader byte address.
- load_wdata, in, 32, loader write data.
- load_gnt, out, 1, loader request accepted this cycle.
- load_rvalid, out, 1, loader response or write acknowledge.
- load_rdata, out, 32, loader read data.
- load_err, out, 1, loader address error, qualified by load_rvalid.
- mem_en, out, 1, BRAM access strobe.
- mem_we, out, 1, BRAM write enable.
- mem_addr, out, AW, BRAM word address.
- mem_wdata, out, 32, BRAM write data.
- mem_rdata, in, 32, BRAM read data, valid one cycle after a mem_en read.

Function
REQ-003 At most one grant SHALL be issued per cycle; the request presented in the grant cycle SHALL be accepted.
REQ-004 fetch_gnt and load_gnt SHALL be combinational from the request inputs and the internal wait counter.
REQ-005 Default priority SHALL be fetch over load.
REQ-006 The wait counter SHALL increment each cycle load_req=1 and load_gnt=0, and clear when load_gnt=1 or load_req=0.
REQ-007 When the wait counter is at least MAX_WAIT, load SHALL be granted over fetch for exactly one cycle.
REQ-008 An address is legal iff addr[1:0]=0 and addr[31:AW+2]=0; the word address SHALL be addr[AW+1:2].
REQ-009 On a legal grant, mem_en SHALL be 1 in the grant cycle, with mem_addr, mem_we (loader only, =load_we) and mem_wdata driven that same cycle.
REQ-010 On an illegal grant, mem_en SHALL be 0, and no BRAM write SHALL occur.
REQ-011 The response SHALL occur exactly one cycle after the grant, pulsing the owner's rvalid for one cycle.
REQ-012 Response data SHALL be:
- rdata = mem_rdata for a legal read.
- rdata = 0 for a write acknowledge or an error.
- err = 1 only for an illegal address.
REQ-013 The registered response owner and kind SHALL hold: owner (none/fetch/load), legal flag, write flag.
REQ-014 Back-to-back grants SHALL be supported, giving throughput of 1 access per cycle.
REQ-015 When no request is pending, mem_en SHALL be 0, mem_we SHALL be 0, and no response SHALL follow.
REQ-016 The non-owner's rvalid SHALL remain 0.
REQ-017 rdata outputs SHALL be 0 when their rvalid is 0.
REQ-018 Write-then-read to the same address on consecutive grants SHALL return the written data, relying on BRAM write-before-next-read ordering.

Reset
REQ-019 While rst=1, all outputs SHALL be 0, the wait counter SHALL be 0 and the owner SHALL be none.
REQ-020 Assertion of rst SHALL immediately drop any in-flight response; no rvalid SHALL follow for that transaction.
REQ-021 The first grant SHALL be possible in the first clk edge cycle after rst deasserts.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Fetch read: preload word 5=0x00000013; fetch_req, addr 0x14 -> fetch_gnt same cycle, mem_addr=5, next cycle fetch_rvalid=1, fetch_rdata=0x00000013, fetch_err=0.
- Loader write then fetch: load write 0xDEADBEEF to 0x100, then fetch 0x100 -> load_rvalid with rdata 0, then fetch_rdata=0xDEADBEEF.
- Starvation: fetch_req and load_req both held high with MAX_WAIT=4 -> load_gnt in the 5th cycle only, then fetch resumes; repeats every 5 cycles.
- Errors: fetch 0x102 and loader 0x00004000 (AW=12) -> mem_en=0, respective err=1, rdata=0.
- Reset mid-operation: assert rst in the cycle after a grant -> no rvalid, outputs 0; the first request after release is served normally.
- Back-to-back fetch 0x0, 0x4, 0x8 -> three consecutive rvalid cycles with data in order.
